cpu_dma_rx_pkt_queue: RTL and testbench

- Parametrised successor to the slim CPU receive FIFO, sitting between the user data path and the CPU DMA read interface.
- Stores whole packets from the pipeline-width bus (DATA_WIDTH) and splits each stored word into DMA_DATA_WIDTH chunks for the DMA engine.
- Advertises data to DMA only once a complete packet is committed.
- New capabilities: configurable depth, store-and-forward commit/rollback, overflow packet drop, packet and drop counters.

---
 rtl/cpu_dma_rx_pkt_queue_pkg.sv | 21 ++
 rtl/cpu_dma_rx_pkt_queue_if.sv | 29 ++
 rtl/cpu_dma_rx_pkt_ram.sv | 24 ++
 rtl/cpu_dma_rx_pkt_queue.sv | 164 ++++++++++++++++
 tb/tb_cpu_dma_rx_pkt_queue.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_dma_rx_pkt_queue_pkg.sv
// Shared definitions for the CPU DMA receive packet queue: input FSM encodings
// and width helpers.
package cpu_dma_rx_pkt_queue_pkg;

  localparam logic [1:0] IN_HDR  = 2'd0;
  localparam logic [1:0] IN_DATA = 2'd1;
  localparam logic [1:0] DROP    = 2'd2;

  // Number of DMA chunks carried by one pipeline word.
  function automatic int unsigned ratio_of(input int unsigned data_w, input int unsigned dma_w);
    return data_w / dma_w;
  endfunction

  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/cpu_dma_rx_pkt_queue_if.sv
// Pipeline-side write bus and DMA-side read bus of the receive packet queue.
interface cpu_dma_rx_pkt_queue_if #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned DMA_DATA_WIDTH = 32,
  parameter int unsigned DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8
);

  logic [DATA_WIDTH-1:0]     in_data;
  logic [CTRL_WIDTH-1:0]     in_ctrl;
  logic                      in_wr;
  logic                      in_rdy;
  logic                      cpu_q_dma_pkt_avail;
  logic                      cpu_q_dma_rd;
  logic [DMA_DATA_WIDTH-1:0] cpu_q_dma_rd_data;
  logic [DMA_CTRL_WIDTH-1:0] cpu_q_dma_rd_ctrl;
  logic                      cpu_q_dma_rd_eop;

  modport master (
    output in_data, in_ctrl, in_wr, cpu_q_dma_rd,
    input  in_rdy, cpu_q_dma_pkt_avail, cpu_q_dma_rd_data, cpu_q_dma_rd_ctrl, cpu_q_dma_rd_eop
  );

  modport slave (
    input  in_data, in_ctrl, in_wr, cpu_q_dma_rd,
    output in_rdy, cpu_q_dma_pkt_avail, cpu_q_dma_rd_data, cpu_q_dma_rd_ctrl, cpu_q_dma_rd_eop
  );

endinterface

// File: rtl/cpu_dma_rx_pkt_ram.sv
// Dual-port RAM: synchronous write, asynchronous read so the head entry falls through.
module cpu_dma_rx_pkt_ram #(
  parameter int unsigned WIDTH     = 73,
  parameter int unsigned ADDR_BITS = 9
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [WIDTH-1:0]     rd_data_o
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/cpu_dma_rx_pkt_queue.sv
// Store-and-forward receive packet queue between the pipeline and the CPU DMA engine.
// Whole packets are committed before being advertised; overflowing packets are dropped.
module cpu_dma_rx_pkt_queue
  import cpu_dma_rx_pkt_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned DMA_DATA_WIDTH = 32,
  parameter int unsigned DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8,
  parameter int unsigned DEPTH_BITS     = 9,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  cpu_dma_rx_pkt_queue_if.slave    bus,
  output logic [DEPTH_BITS:0]      pkt_count,
  output logic [CNT_WIDTH-1:0]     drop_count,
  output logic                     pkt_dropped
);

  localparam int unsigned RATIO       = ratio_of(DATA_WIDTH, DMA_DATA_WIDTH);
  localparam int unsigned CHUNK_BITS  = (RATIO > 1) ? log2_ceil(RATIO) : 1;
  localparam int unsigned ENTRY_WIDTH = 1 + CTRL_WIDTH + DATA_WIDTH;
  localparam logic [DEPTH_BITS:0] DEPTH = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [CHUNK_BITS-1:0] LAST_CHUNK = CHUNK_BITS'(RATIO - 1);

  logic [DEPTH_BITS:0]   wr_ptr_q, commit_ptr_q, rd_ptr_q;
  logic [CHUNK_BITS-1:0] chunk_idx_q;
  logic [DEPTH_BITS:0]   pkt_cnt_q;
  logic [CNT_WIDTH-1:0]  drop_cnt_q;
  logic                  dropped_q;
  logic [1:0]            in_state_q, in_state_d;
  logic                  drop_armed_q, drop_armed_d;

  logic                  full, in_active, overflow, wr_accept, wr_eop;
  logic                  rd_fire, rd_last, rd_eop_fire;
  logic [ENTRY_WIDTH-1:0] head;
  logic                  head_eop;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DMA_DATA_WIDTH-1:0] chunk_data;
  logic [DMA_CTRL_WIDTH-1:0] chunk_ctrl;

  // Occupancy counts uncommitted words too, so a packet longer than the depth always drops.
  assign full      = (wr_ptr_q - rd_ptr_q) == DEPTH;
  assign in_active = bus.in_wr && (in_state_q != DROP);
  assign overflow  = in_active && full;
  assign wr_accept = in_active && !full;
  assign wr_eop    = wr_accept && (in_state_q == IN_DATA) && (bus.in_ctrl != '0);

  assign rd_fire     = bus.cpu_q_dma_rd && (pkt_cnt_q != '0);
  assign rd_last     = chunk_idx_q == LAST_CHUNK;
  assign rd_eop_fire = rd_fire && rd_last && head_eop;

  // drop_armed records that the dropped packet has already seen a data word, so the
  // next non-zero ctrl is its last word rather than a header of the same packet.
  always_comb begin
    in_state_d   = in_state_q;
    drop_armed_d = drop_armed_q;
    if (bus.in_wr) begin
      case (in_state_q)
        IN_HDR: begin
          if (full) begin
            in_state_d   = DROP;
            drop_armed_d = (bus.in_ctrl == '0);
          end else if (bus.in_ctrl == '0) begin
            in_state_d = IN_DATA;
          end
        end
        IN_DATA: begin
          if (bus.in_ctrl != '0) begin
            // An overflowing last word ends its own packet; nothing left to discard.
            in_state_d = IN_HDR;
          end else if (full) begin
            in_state_d   = DROP;
            drop_armed_d = 1'b1;
          end
        end
        DROP: begin
          if (bus.in_ctrl == '0) begin
            drop_armed_d = 1'b1;
          end else if (drop_armed_q) begin
            in_state_d = IN_HDR;
          end
        end
        default: in_state_d = IN_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      chunk_idx_q  <= '0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      dropped_q    <= 1'b0;
      in_state_q   <= IN_HDR;
      drop_armed_q <= 1'b0;
    end else begin
      dropped_q    <= overflow;
      in_state_q   <= in_state_d;
      drop_armed_q <= drop_armed_d;
      if (overflow) begin
        wr_ptr_q <= commit_ptr_q;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      end else if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (wr_eop) commit_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) begin
        if (rd_last) begin
          chunk_idx_q <= '0;
          rd_ptr_q    <= rd_ptr_q + 1'b1;
        end else begin
          chunk_idx_q <= chunk_idx_q + 1'b1;
        end
      end
      case ({wr_eop, rd_eop_fire})
        2'b10:   pkt_cnt_q <= pkt_cnt_q + 1'b1;
        2'b01:   pkt_cnt_q <= pkt_cnt_q - 1'b1;
        default: pkt_cnt_q <= pkt_cnt_q;
      endcase
    end
  end

  cpu_dma_rx_pkt_ram #(
    .WIDTH     (ENTRY_WIDTH),
    .ADDR_BITS (DEPTH_BITS)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (wr_accept && !reset),
    .wr_addr_i (wr_ptr_q[DEPTH_BITS-1:0]),
    .wr_data_i ({wr_eop, bus.in_ctrl, bus.in_data}),
    .rd_addr_i (rd_ptr_q[DEPTH_BITS-1:0]),
    .rd_data_o (head)
  );

  assign {head_eop, head_ctrl, head_data} = head;

  // Chunk 0 is the most significant slice of the stored word.
  always_comb begin
    chunk_data = '0;
    chunk_ctrl = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (chunk_idx_q == CHUNK_BITS'(k)) begin
        chunk_data = head_data[DATA_WIDTH-1-k*DMA_DATA_WIDTH -: DMA_DATA_WIDTH];
        chunk_ctrl = head_ctrl[CTRL_WIDTH-1-k*DMA_CTRL_WIDTH -: DMA_CTRL_WIDTH];
      end
    end
  end

  assign bus.in_rdy              = !reset;
  assign bus.cpu_q_dma_pkt_avail = !reset && (pkt_cnt_q != '0);
  assign bus.cpu_q_dma_rd_data   = reset ? '0 : chunk_data;
  assign bus.cpu_q_dma_rd_ctrl   = reset ? '0 : chunk_ctrl;
  assign bus.cpu_q_dma_rd_eop    = !reset && head_eop && rd_last;
  assign pkt_count               = reset ? '0 : pkt_cnt_q;
  assign drop_count              = reset ? '0 : drop_cnt_q;
  assign pkt_dropped             = !reset && dropped_q;

endmodule

// File: tb/tb_cpu_dma_rx_pkt_queue.sv
// Bench for the receive packet queue: packet-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cpu_dma_rx_pkt_queue;

  localparam int unsigned DW    = 64;
  localparam int unsigned CW    = 8;
  localparam int unsigned DDW   = 32;
  localparam int unsigned DCW   = 4;
  localparam int unsigned DB    = 4;
  localparam int unsigned CNTW  = 16;
  localparam int unsigned RATIO = DW / DDW;
  localparam int unsigned DEPTH = 2 ** DB;

  logic clk;
  logic reset;
  logic [DB:0]     pkt_count;
  logic [CNTW-1:0] drop_count;
  logic            pkt_dropped;

  cpu_dma_rx_pkt_queue_if #(
    .DATA_WIDTH     (DW),
    .CTRL_WIDTH     (CW),
    .DMA_DATA_WIDTH (DDW),
    .DMA_CTRL_WIDTH (DCW)
  ) bus ();

  cpu_dma_rx_pkt_queue #(
    .DATA_WIDTH     (DW),
    .CTRL_WIDTH     (CW),
    .DMA_DATA_WIDTH (DDW),
    .DMA_CTRL_WIDTH (DCW),
    .DEPTH_BITS     (DB),
    .CNT_WIDTH      (CNTW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .pkt_count   (pkt_count),
    .drop_count  (drop_count),
    .pkt_dropped (pkt_dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (packet level) ----------------
  typedef struct packed {
    logic [DDW-1:0] data;
    logic [DCW-1:0] ctrl;
    logic           eop;
  } chunk_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    logic          eop;
  } word_t;

  chunk_t      chunk_q[$];  // committed, not yet consumed
  word_t       pend_q[$];   // current packet, not yet committed
  int          m_pkt;
  int unsigned m_drop;
  logic        m_pulse;
  logic        m_in_drop;
  logic        m_seen;
  int unsigned m_stored;
  logic        m_is_eop;
  logic        m_rd_done;
  chunk_t      mc;
  word_t       mw;

  initial begin
    m_pkt = 0; m_drop = 0; m_pulse = 0; m_in_drop = 0; m_seen = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        chunk_q.delete();
        pend_q.delete();
        m_pkt = 0; m_drop = 0; m_pulse = 0; m_in_drop = 0; m_seen = 0;
      end else begin
        m_stored  = (chunk_q.size() + RATIO - 1) / RATIO + pend_q.size();
        m_pulse   = 1'b0;
        m_rd_done = 1'b0;
        if (bus.cpu_q_dma_rd && m_pkt != 0) begin
          mc = chunk_q.pop_front();
          m_rd_done = mc.eop;
        end
        if (bus.in_wr) begin
          m_is_eop = (bus.in_ctrl != '0) && m_seen;
          if (m_in_drop) begin
            if (m_is_eop) begin
              m_in_drop = 1'b0;
              m_seen    = 1'b0;
            end else if (bus.in_ctrl == '0) begin
              m_seen = 1'b1;
            end
          end else if (m_stored == DEPTH) begin
            pend_q.delete();
            m_pulse = 1'b1;
            if (m_drop != 65535) m_drop++;
            if (m_is_eop) m_seen = 1'b0;
            else begin
              m_in_drop = 1'b1;
              if (bus.in_ctrl == '0) m_seen = 1'b1;
            end
          end else begin
            mw.data = bus.in_data;
            mw.ctrl = bus.in_ctrl;
            mw.eop  = m_is_eop;
            pend_q.push_back(mw);
            if (m_is_eop) begin
              foreach (pend_q[w]) begin
                for (int k = 0; k < RATIO; k++) begin
                  mc.data = DDW'(pend_q[w].data >> ((RATIO - 1 - k) * DDW));
                  mc.ctrl = DCW'(pend_q[w].ctrl >> ((RATIO - 1 - k) * DCW));
                  mc.eop  = pend_q[w].eop && (k == RATIO - 1);
                  chunk_q.push_back(mc);
                end
              end
              pend_q.delete();
              m_pkt++;
              m_seen = 1'b0;
            end else if (bus.in_ctrl == '0) begin
              m_seen = 1'b1;
            end
          end
        end
        if (m_rd_done) m_pkt--;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        check("rst_in_rdy", bus.in_rdy, 0);
        check("rst_pkt_avail", bus.cpu_q_dma_pkt_avail, 0);
        check("rst_rd_data", bus.cpu_q_dma_rd_data, 0);
        check("rst_rd_eop", bus.cpu_q_dma_rd_eop, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_pkt_dropped", pkt_dropped, 0);
      end else begin
        check("in_rdy", bus.in_rdy, 1);
        check("pkt_avail", bus.cpu_q_dma_pkt_avail, (m_pkt != 0));
        check("pkt_count", pkt_count, 64'(m_pkt));
        check("drop_count", drop_count, 64'(m_drop));
        check("pkt_dropped", pkt_dropped, m_pulse);
        if (m_pkt != 0) begin
          check("rd_data", bus.cpu_q_dma_rd_data, chunk_q[0].data);
          check("rd_ctrl", bus.cpu_q_dma_rd_ctrl, chunk_q[0].ctrl);
          check("rd_eop", bus.cpu_q_dma_rd_eop, chunk_q[0].eop);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [DW-1:0] wdata(input int p, input int i);
    return {8'(p), 24'(i), 8'(p) ^ 8'hA5, 24'(i + 'h100)};
  endfunction

  function automatic logic [CW-1:0] wctrl(input int nhdr, input int ndata, input int i);
    if (i < nhdr) return 8'hFF;
    if (i < nhdr + ndata) return 8'h00;
    return 8'h80;
  endfunction

  task automatic put_word(input logic [DW-1:0] d, input logic [CW-1:0] c);
    bus.in_wr   = 1'b1;
    bus.in_data = d;
    bus.in_ctrl = c;
    @(negedge clk);
    bus.in_wr   = 1'b0;
    bus.in_data = '0;
    bus.in_ctrl = '0;
  endtask

  task automatic send_pkt(input int p, input int nhdr, input int ndata);
    for (int i = 0; i < nhdr + ndata + 1; i++) put_word(wdata(p, i), wctrl(nhdr, ndata, i));
  endtask

  task automatic dma_read(input int n);
    bus.cpu_q_dma_rd = 1'b1;
    repeat (n) @(negedge clk);
    bus.cpu_q_dma_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.in_wr = 1'b0;
    bus.in_data = '0;
    bus.in_ctrl = '0;
    bus.cpu_q_dma_rd = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single packet: 2 headers, 3 data, 1 last word.
    for (int i = 0; i < 5; i++) put_word(wdata(1, i), wctrl(2, 3, i));
    check("t1_avail_before_eop", bus.cpu_q_dma_pkt_avail, 0);
    put_word(wdata(1, 5), wctrl(2, 3, 5));
    check("t1_avail_after_eop", bus.cpu_q_dma_pkt_avail, 1);
    check("t1_pkt_count", pkt_count, 1);
    check("t1_model_pkt", 64'(m_pkt), 1);
    check("t1_chunk0", bus.cpu_q_dma_rd_data, 32'h0100_0000);
    check("t1_model_chunk0", chunk_q[0].data, 32'h0100_0000);
    check("t1_chunk0_ctrl", bus.cpu_q_dma_rd_ctrl, 4'hF);
    dma_read(1);
    check("t1_chunk1", bus.cpu_q_dma_rd_data, 32'hA400_0100);
    dma_read(10);
    check("t1_chunk12_data", bus.cpu_q_dma_rd_data, 32'hA400_0105);
    check("t1_chunk12_eop", bus.cpu_q_dma_rd_eop, 1);
    check("t1_chunk12_ctrl", bus.cpu_q_dma_rd_ctrl, 4'h0);
    dma_read(1);
    check("t1_drained_count", pkt_count, 0);
    check("t1_drained_avail", bus.cpu_q_dma_pkt_avail, 0);

    // Two back-to-back packets, DMA idle.
    send_pkt(2, 1, 1);
    send_pkt(3, 1, 2);
    check("t2_two_pkts", pkt_count, 2);
    dma_read(6);
    check("t2_one_left", pkt_count, 1);
    check("t2_avail", bus.cpu_q_dma_pkt_avail, 1);
    check("t2_second_head", bus.cpu_q_dma_rd_data, 32'h0300_0000);
    dma_read(8);
    check("t2_drained", pkt_count, 0);

    // 20-word packet overflows a 16-entry queue on word 17.
    for (int i = 0; i < 16; i++) put_word(wdata(4, i), wctrl(2, 17, i));
    check("t3_no_drop_yet", pkt_dropped, 0);
    put_word(wdata(4, 16), wctrl(2, 17, 16));
    check("t3_drop_pulse", pkt_dropped, 1);
    check("t3_drop_count", drop_count, 1);
    check("t3_model_drop", 64'(m_drop), 1);
    for (int i = 17; i < 20; i++) put_word(wdata(4, i), wctrl(2, 17, i));
    check("t3_pulse_gone", pkt_dropped, 0);
    check("t3_avail_low", bus.cpu_q_dma_pkt_avail, 0);
    send_pkt(5, 1, 2);
    check("t3_next_pkt", pkt_count, 1);
    check("t3_next_head", bus.cpu_q_dma_rd_data, 32'h0500_0000);
    dma_read(8);
    check("t3_drained", pkt_count, 0);

    // Committed 10-word packet survives a second 10-word packet overflowing.
    send_pkt(6, 1, 8);
    for (int i = 0; i < 10; i++) put_word(wdata(7, i), wctrl(1, 8, i));
    check("t4_drop_count", drop_count, 2);
    check("t4_pkt_count", pkt_count, 1);
    check("t4_head", bus.cpu_q_dma_rd_data, 32'h0600_0000);
    dma_read(20);
    check("t4_drained", pkt_count, 0);
    send_pkt(8, 1, 1);
    check("t4_after_rollback", bus.cpu_q_dma_rd_data, 32'h0800_0000);
    dma_read(6);

    // EOP commit and final EOP read in the same cycle.
    send_pkt(9, 1, 1);
    dma_read(5);
    check("t5_last_chunk_eop", bus.cpu_q_dma_rd_eop, 1);
    put_word(wdata(10, 0), wctrl(1, 1, 0));
    put_word(wdata(10, 1), wctrl(1, 1, 1));
    bus.cpu_q_dma_rd = 1'b1;
    put_word(wdata(10, 2), wctrl(1, 1, 2));
    bus.cpu_q_dma_rd = 1'b0;
    check("t5_count_held", pkt_count, 1);
    check("t5_avail_held", bus.cpu_q_dma_pkt_avail, 1);
    check("t5_new_head", bus.cpu_q_dma_rd_data, 32'h0A00_0000);
    dma_read(6);

    // Reset on the 3rd word of a packet, with another packet still committed.
    send_pkt(12, 1, 1);
    put_word(wdata(11, 0), 8'hFF);
    put_word(wdata(11, 1), 8'h00);
    bus.in_wr   = 1'b1;
    bus.in_data = wdata(11, 2);
    bus.in_ctrl = 8'h00;
    reset       = 1'b1;
    #1;
    check("t6_rdy_in_reset", bus.in_rdy, 0);
    check("t6_count_in_reset", pkt_count, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.in_wr = 1'b0;
    bus.in_ctrl = '0;
    bus.in_data = '0;
    #1;
    check("t6_count_after", pkt_count, 0);
    check("t6_avail_after", bus.cpu_q_dma_pkt_avail, 0);
    check("t6_rdy_after", bus.in_rdy, 1);
    check("t6_drops_cleared", drop_count, 0);
    send_pkt(13, 2, 3);
    check("t6_new_pkt", pkt_count, 1);
    check("t6_new_head", bus.cpu_q_dma_rd_data, 32'h0D00_0000);
    dma_read(12);
    check("t6_drained", pkt_count, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
